// File: rtl/span_raster_if.sv
`default_nettype none
// ============================================================================
// Module   : span_raster_if
// Brief    : Span command handshake plus rasterizer-to-writer FIFO write port.
// Revision : 1.0
// ============================================================================
interface span_raster_if #(
  parameter int RAST_FBW_FIFO_LEN = 96,
  parameter int LINE_LEN          = 9,
  parameter int COL_LEN           = 10
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [0:LINE_LEN-1]          cmd_line;
  logic [0:COL_LEN-1]           cmd_x0;
  logic [0:COL_LEN-1]           cmd_x1;
  logic [0:31]                  cmd_color;
  logic                         fifo_full;
  logic                         fifo_wr_en;
  logic [0:RAST_FBW_FIFO_LEN-1] fifo_din;

  // master: command source and FIFO side; slave: the rasterizer
  modport master (
    output cmd_valid, cmd_line, cmd_x0, cmd_x1, cmd_color, fifo_full,
    input  cmd_ready, fifo_wr_en, fifo_din
  );

  modport slave (
    input  cmd_valid, cmd_line, cmd_x0, cmd_x1, cmd_color, fifo_full,
    output cmd_ready, fifo_wr_en, fifo_din
  );
endinterface
`default_nettype wire

// File: rtl/span_raster.sv
`default_nettype none
// ============================================================================
// Module   : span_raster
// Brief    : Clips horizontal span commands and expands them into per-pixel FIFO words.
// Revision : 1.0
// ============================================================================
module span_raster #(
  parameter int RAST_FBW_FIFO_LEN = 96,
  parameter int LINE_LEN          = 9,
  parameter int COL_LEN           = 10,
  parameter int SCREEN_W          = 640,
  parameter int SCREEN_H          = 480
) (
  input  wire logic    PLB_clk,
  input  wire logic    reset_n,
  span_raster_if.slave bus,
  output logic         busy,
  output logic [0:31]  pix_count,
  output logic [0:15]  drop_count
);

  localparam logic [COL_LEN-1:0] c_x_max    = COL_LEN'(SCREEN_W - 1);
  localparam logic [LINE_LEN:0]  c_line_lim = (LINE_LEN + 1)'(SCREEN_H);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLIP = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [LINE_LEN-1:0] r_line;
  logic [COL_LEN-1:0]  r_x0;
  logic [COL_LEN-1:0]  r_x1;
  logic [COL_LEN-1:0]  r_col;
  logic [31:0]         r_color;
  logic [31:0]         r_pix_count;
  logic [15:0]         r_drop_count;

  logic [COL_LEN-1:0]  w_x_end;
  logic                w_drop;
  logic                w_write;

  assign w_x_end = (r_x1 > c_x_max) ? c_x_max : r_x1;
  // Reversed spans fall out naturally here: x0 > x1 implies x0 > x_end.
  assign w_drop  = ({1'b0, r_line} >= c_line_lim) || (r_x0 > w_x_end);
  assign w_write = (r_state == S_EMIT) && !bus.fifo_full;

  always_ff @(posedge PLB_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_line       <= '0;
      r_x0         <= '0;
      r_x1         <= '0;
      r_col        <= '0;
      r_color      <= '0;
      r_pix_count  <= '0;
      r_drop_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_line  <= bus.cmd_line;
            r_x0    <= bus.cmd_x0;
            r_x1    <= bus.cmd_x1;
            r_color <= bus.cmd_color;
            r_state <= S_CLIP;
          end
        end
        S_CLIP: begin
          if (w_drop) begin
            if (r_drop_count != 16'hFFFF) begin
              r_drop_count <= r_drop_count + 16'd1;
            end
            r_state <= S_IDLE;
          end else begin
            r_col   <= r_x0;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          // A stalled cycle holds col so the same pixel is offered again.
          if (w_write) begin
            r_pix_count <= r_pix_count + 32'd1;
            if (r_col == w_x_end) begin
              r_state <= S_IDLE;
            end else begin
              r_col <= r_col + COL_LEN'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = reset_n && (r_state == S_IDLE);
  assign bus.fifo_wr_en = w_write;
  assign bus.fifo_din   = RAST_FBW_FIFO_LEN'({16'(r_line), 16'(r_col), r_color, 32'h0});
  assign busy           = (r_state != S_IDLE);
  assign pix_count      = r_pix_count;
  assign drop_count     = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_span_raster.sv
`default_nettype none
// ============================================================================
// Module   : tb_span_raster
// Brief    : Directed and randomized checks of span_raster against a span-level model.
// Revision : 1.0
// ============================================================================
module tb_span_raster;

  localparam int c_w = 640;
  localparam int c_h = 480;

  logic PLB_clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 PLB_clk = ~PLB_clk;

  span_raster_if bus ();

  logic        busy;
  logic [0:31] pix_count;
  logic [0:15] drop_count;
  logic        full_dir = 1'b0;
  logic        full_rnd = 1'b0;
  logic        rnd_en   = 1'b0;

  assign bus.fifo_full = full_dir | full_rnd;

  span_raster dut (
    .PLB_clk    (PLB_clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .busy       (busy),
    .pix_count  (pix_count),
    .drop_count (drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge PLB_clk) cyc <= cyc + 1;

  always @(posedge PLB_clk) begin
    #1;
    full_rnd <= rnd_en ? ($urandom_range(0, 2) == 0) : 1'b0;
  end

  logic [95:0] got_q[$];
  int          got_cyc[$];
  logic [95:0] exp_q[$];
  logic [31:0] m_pix  = '0;
  logic [15:0] m_drop = '0;

  always @(negedge PLB_clk) begin
    if (bus.fifo_wr_en === 1'b1) begin
      n_checks++;
      assert (bus.fifo_full === 1'b0) else begin
        n_fail++;
        $error("FAIL wr_while_full: observed full=%0b expected 0", bus.fifo_full);
      end
      got_q.push_back(bus.fifo_din);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Span-level reference: clip, then one word per visible column.
  task automatic model_span(input int line, input int x0, input int x1, input logic [31:0] color);
    int xe;
    xe = (x1 < c_w) ? x1 : c_w - 1;
    if (line >= c_h || x0 > xe) begin
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end else begin
      for (int c = x0; c <= xe; c++) begin
        exp_q.push_back({16'(line), 16'(c), color, 32'h0});
        m_pix = m_pix + 32'd1;
      end
    end
  endtask

  task automatic send(input int line, input int x0, input int x1, input logic [31:0] color,
                      input bit keep, output int acc);
    int t;
    @(negedge PLB_clk);
    bus.cmd_line  = 9'(line);
    bus.cmd_x0    = 10'(x0);
    bus.cmd_x1    = 10'(x1);
    bus.cmd_color = color;
    bus.cmd_valid = 1'b1;
    t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 2000) begin
      @(negedge PLB_clk);
      t++;
    end
    chk("accept_timeout", 96'(t >= 2000), 96'(0));
    acc = cyc;
    model_span(line, x0, x1, color);
    @(posedge PLB_clk);
    #1;
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    @(negedge PLB_clk);
    t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 5000) begin
      @(negedge PLB_clk);
      t++;
    end
    #1;
    chk({tag, "_timeout"}, 96'(t >= 5000), 96'(0));
    chk({tag, "_nwrites"}, 96'(got_q.size()), 96'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_entry"}, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
    chk({tag, "_pix"}, 96'(pix_count), 96'(m_pix));
    chk({tag, "_drop"}, 96'(drop_count), 96'(m_drop));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, a1, a2, a3, t, ln, x0, x1;
    bus.cmd_valid = 1'b0;
    bus.cmd_line  = '0;
    bus.cmd_x0    = '0;
    bus.cmd_x1    = '0;
    bus.cmd_color = '0;

    // Reset values
    #3 reset_n = 1'b0;
    #4;
    chk("rst_ready", 96'(bus.cmd_ready), 96'(0));
    chk("rst_wr_en", 96'(bus.fifo_wr_en), 96'(0));
    chk("rst_din", 96'(bus.fifo_din), 96'(0));
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_pix", 96'(pix_count), 96'(0));
    chk("rst_drop", 96'(drop_count), 96'(0));
    repeat (2) @(negedge PLB_clk);
    reset_n = 1'b1;
    @(negedge PLB_clk);
    #1 chk("rst_ready_after", 96'(bus.cmd_ready), 96'(1));

    // Basic span with exact latency and ready timing
    send(5, 10, 13, 32'hDEADBEEF, 1'b0, acc);
    bus.cmd_line = 9'h1FF; bus.cmd_x0 = 10'h3FF; bus.cmd_x1 = 10'h0; bus.cmd_color = 32'h0BAD_F00D;
    repeat (5) @(negedge PLB_clk);
    #1 chk("basic_ready_last_write", 96'(bus.cmd_ready), 96'(0));
    @(negedge PLB_clk);
    #1 chk("basic_ready_after", 96'(bus.cmd_ready), 96'(1));
    chk("basic_first_cyc", 96'(got_cyc[0]), 96'(acc + 2));
    chk("basic_last_cyc", 96'(got_cyc[3]), 96'(acc + 5));
    chk("basic_layout", got_q[0], {16'd5, 16'd10, 32'hDEADBEEF, 32'h0});
    drain("basic");

    // Clipping and drops
    send(479, 630, 1000, 32'h1234_5678, 1'b0, acc);
    drain("clip_right");
    send(480, 3, 9, 32'hFFFF_0000, 1'b0, acc);
    drain("clip_line");
    send(20, 20, 19, 32'hAAAA_5555, 1'b0, acc);
    drain("clip_reversed");
    send(0, 639, 639, 32'h0000_0001, 1'b0, acc);
    drain("clip_single_edge");

    // Backpressure: full on EMIT cycles 1 and 3..5
    send(100, 0, 7, 32'hCAFE_0001, 1'b0, acc);
    for (int e = 1; e <= 12; e++) begin
      @(posedge PLB_clk);
      #1 full_dir = (e == 1) || (e >= 3 && e <= 5);
    end
    full_dir = 1'b0;
    drain("backpressure");

    // Back-to-back single pixels with cmd_valid held high
    send(1, 1, 1, 32'h0000_0011, 1'b1, a1);
    send(2, 2, 2, 32'h0000_0022, 1'b1, a2);
    send(3, 3, 3, 32'h0000_0033, 1'b0, a3);
    repeat (4) @(negedge PLB_clk);
    #1;
    chk("b2b_gap1", 96'(got_cyc[1] - got_cyc[0]), 96'(3));
    chk("b2b_gap2", 96'(got_cyc[2] - got_cyc[1]), 96'(3));
    drain("b2b");

    // Randomized spans under random backpressure
    rnd_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ln = ($urandom_range(0, 7) == 0) ? $urandom_range(480, 511) : $urandom_range(0, 479);
      x0 = $urandom_range(0, 650);
      if ($urandom_range(0, 4) == 0) x1 = $urandom_range(0, 1023);
      else x1 = x0 + $urandom_range(0, 14);
      send(ln, x0, x1, $urandom(), 1'b0, acc);
      repeat ($urandom_range(0, 3)) @(negedge PLB_clk);
    end
    drain("random");
    rnd_en = 1'b0;
    repeat (2) @(negedge PLB_clk);

    // drop_count saturation
    force dut.r_drop_count = 16'hFFFE;
    #1 release dut.r_drop_count;
    m_drop = 16'hFFFE;
    #1 chk("sat_forced", 96'(drop_count), 96'(16'hFFFE));
    for (int i = 0; i < 3; i++) begin
      send(500 + i, 1, 2, 32'h0, 1'b0, acc);
      drain("sat");
    end

    // pix_count wrap
    @(negedge PLB_clk);
    force dut.r_pix_count = 32'hFFFF_FFFF;
    #1 release dut.r_pix_count;
    m_pix = 32'hFFFF_FFFF;
    send(9, 9, 9, 32'h9999_9999, 1'b0, acc);
    drain("wrap");
    chk("wrap_zero", 96'(pix_count), 96'(0));

    // Asynchronous reset in the middle of a long span
    send(7, 0, 99, 32'h7777_7777, 1'b0, acc);
    t = 0;
    while (got_q.size() < 10 && t < 200) begin
      @(negedge PLB_clk);
      #1;
      t++;
    end
    chk("midrst_pre_wr", 96'(bus.fifo_wr_en), 96'(1));
    reset_n = 1'b0;
    #1;
    chk("midrst_wr_en", 96'(bus.fifo_wr_en), 96'(0));
    chk("midrst_busy", 96'(busy), 96'(0));
    chk("midrst_pix", 96'(pix_count), 96'(0));
    chk("midrst_drop", 96'(drop_count), 96'(0));
    chk("midrst_ready", 96'(bus.cmd_ready), 96'(0));
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    m_pix  = '0;
    m_drop = '0;
    @(negedge PLB_clk);
    reset_n = 1'b1;
    repeat (20) @(negedge PLB_clk);
    #1;
    chk("midrst_no_writes", 96'(got_q.size()), 96'(0));
    chk("midrst_ready_after", 96'(bus.cmd_ready), 96'(1));
    chk("midrst_pix_after", 96'(pix_count), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/span_raster.md
# span_raster

Span rasterizer stage directly upstream of the frame-buffer writer. It accepts horizontal span commands (one screen line, start column, end column, 32-bit color) and clips each span to the screen. It then expands the span into one 96-bit pixel entry per column, pushed into the rasterizer-to-writer FIFO. Entries use the exact FIFO word layout the frame-buffer writer dequeues, and the block stalls on FIFO full.

## Interface
- RAST_FBW_FIFO_LEN, 96, FIFO word width
- LINE_LEN, 9, line (y) field width
- COL_LEN, 10, column (x) field width
- SCREEN_W, 640, visible columns; valid col 0..SCREEN_W-1
- SCREEN_H, 480, visible lines; valid line 0..SCREEN_H-1
- PLB_clk  in  1  sole clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  span command present
- cmd_ready  out  1  block can accept a command
- cmd_line  in  [0:LINE_LEN-1]  span line
- cmd_x0  in  [0:COL_LEN-1]  first column, inclusive
- cmd_x1  in  [0:COL_LEN-1]  last column, inclusive
- cmd_color  in  [0:31]  pixel color
- fifo_full  in  1  FIFO cannot accept a write this cycle
- fifo_wr_en  out  1  write fifo_din this cycle
- fifo_din  out  [0:RAST_FBW_FIFO_LEN-1]  pixel entry
- busy  out  1  state != IDLE
- pix_count  out  [0:31]  pixels written since reset, wraps
- drop_count  out  [0:15]  spans rejected by clipping, saturates at 16'hFFFF

## Operation
- **Entry layout** (bit 0 = MSB):
  - [0:15] = line, zero-extended, right-justified (line in [16-LINE_LEN:15])
  - [16:31] = column, right-justified (column in [32-COL_LEN:31])
  - [32:63] = color
  - [64:95] = 0
- **States:** IDLE, CLIP, EMIT.
- **IDLE:**
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready: latch line, x0, x1, color; go to CLIP.
- **CLIP** (one cycle, cmd_ready = 0):
  - x_end = min(x1, SCREEN_W-1).
  - If line >= SCREEN_H or x0 > x_end: increment drop_count (saturating), go to IDLE, no writes.
  - Otherwise: col <= x0, go to EMIT.
- **EMIT:**
  - fifo_wr_en = !fifo_full (combinational); fifo_din is driven from registers.
  - On a write: pix_count++. If col == x_end, go to IDLE; else col++.
  - While fifo_full: hold col and state, fifo_wr_en = 0.
- Reversed spans (x0 > x1) are drops, not swaps.
- Single-pixel span (x0 == x1): exactly one write.
- Outputs must never assert fifo_wr_en while fifo_full is high.
- cmd_* inputs are ignored outside an IDLE handshake; the latched copy is used for the whole span.

## Timing
- **Reset values:** state IDLE, cmd_ready 0 while reset_n low (1 after release), fifo_wr_en 0, fifo_din 0, busy 0, pix_count 0, drop_count 0, col 0.
- **Reset mid-span:**
  - Immediate, asynchronous: fifo_wr_en deasserts without waiting for a clock edge.
  - The remaining pixels are discarded and no partial recovery is attempted.
- **Latency** (command accepted at edge N):
  - CLIP occupies cycle N..N+1.
  - First fifo_wr_en is high in the cycle after edge N+1.
- **Throughput:**
  - Unstalled span of L pixels: L consecutive write cycles.
  - cmd_ready re-asserts the cycle after the last write.
  - Span period = L+2 cycles. Dropped span period = 2 cycles.
- **FIFO full:**
  - fifo_full is sampled in the same cycle as the write decision.
  - Deassertion resumes writing in that same cycle with the held column; no pixel is skipped or duplicated.
- **Counter wrap:** pix_count wraps 32'hFFFFFFFF -> 0. drop_count holds at 16'hFFFF.

## Test plan
- **Reset:** reset_n low asynchronously mid-EMIT (span 0..99, after 10 writes) -> fifo_wr_en 0 the same cycle, busy 0, counters 0; after release cmd_ready 1 and no further writes.
- **Basic span:** line 5, x0 10, x1 13, color 32'hDEADBEEF, fifo_full 0 -> 4 consecutive writes, first 2 cycles after accept. fifo_din[0:15] = 5; [16:31] = 10,11,12,13; [32:63] = DEADBEEF; [64:95] = 0. pix_count = 4; cmd_ready high the next cycle.
- **Clipping:** line 479, x0 630, x1 1000 -> cols 630..639, 10 writes. Line 480, any x -> 0 writes, drop_count 1. x0 20, x1 19 -> 0 writes, drop_count 2.
- **Backpressure:** span 0..7 with fifo_full high for cycles 3-5 of EMIT and on the first EMIT cycle -> exactly 8 writes, cols strictly 0..7. No fifo_wr_en while full.
- **Back-to-back:** three 1-pixel spans presented with cmd_valid held high -> one write every 3 cycles, in command order. pix_count = 3.
- **Saturation and wrap:** force drop_count to 16'hFFFE, issue 3 invalid spans -> drop_count = 16'hFFFF. Force pix_count to 32'hFFFFFFFF, issue 1 pixel -> pix_count = 0.
